// File: rtl/mul_acc_reconstructor_if.sv
// Handshake and operand bus for the shift-add multiply-accumulate unit.
// The master drives the request and operands. The slave returns status and the product.
interface mul_acc_reconstructor_if #(
    parameter int WIDTH = 16
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     c;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b, c,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b, c,
        output busy, done, product
    );
endinterface

// File: rtl/mul_acc_reconstructor.sv
// Sequential radix-2 shift-add unit: product = a*b + c, retiring one multiplier bit per clock.
// It rebuilds a dividend from the quotient, divisor and remainder.
module mul_acc_reconstructor #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mul_acc_reconstructor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [2*WIDTH:0]     r_p;
    logic [WIDTH-1:0]     r_a_q;
    logic [CW-1:0]        r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH:0]       w_upper;
    logic [2*WIDTH:0]     w_shift;

    // The upper part is WIDTH+1 bits, so the carry from adding a_q is kept before the shift.
    always_comb begin
        w_upper = r_p[2*WIDTH:WIDTH] + (r_p[0] ? {1'b0, r_a_q} : '0);
        w_shift = {1'b0, w_upper, r_p[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_p       <= '0;
            r_a_q     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a_q   <= bus.a;
                        r_p     <= {1'b0, bus.c, bus.b};
                        r_cnt   <= CW'(WIDTH);
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_p   <= w_shift;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_product <= w_shift[2*WIDTH-1:0];
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;
endmodule

// File: tb/tb_mul_acc_reconstructor.sv
// Scoreboard bench for mul_acc_reconstructor. Expected products come from a*b+c in plain arithmetic.
// The expected done cycle is the accept edge plus WIDTH.
module tb_mul_acc_reconstructor;
    localparam int W = 16;

    typedef struct {
        logic [63:0] prod;
        logic [63:0] cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [63:0] cyc;
    logic [31:0] last_prod;
    int total;
    int bad;
    exp_t sb[$];

    mul_acc_reconstructor_if #(.WIDTH(W)) bus ();

    mul_acc_reconstructor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = '0;
    always @(posedge clk) cyc <= cyc + 64'd1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
        end
    endfunction

    function automatic void push(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                                 input logic [63:0] done_cyc);
        exp_t e;
        e.prod = 64'(32'(a) * 32'(b) + 32'(c));
        e.cyc  = done_cyc;
        sb.push_back(e);
    endfunction

    // Monitor: each done pulse is compared with the oldest expected job.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", 64'(bus.product), e.prod);
                check("done_cycle", cyc, e.cyc);
                check("busy_at_done", 64'(bus.busy), 64'd0);
                last_prod = e.prod[31:0];
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic run_job(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                           input int ignore_at);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.c = c; bus.start = 1'b1;
        push(a, b, c, cyc + 64'd1 + 64'(W));
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = 16'($urandom); bus.b = 16'($urandom); bus.c = 16'($urandom);
        for (int i = 0; i < W; i++) begin
            check("busy_run", 64'(bus.busy), 64'd1);
            check("done_run", 64'(bus.done), 64'd0);
            check("product_hold", 64'(bus.product), 64'(last_prod));
            if (i == ignore_at) begin
                bus.start = 1'b1; bus.a = 16'd7; bus.b = 16'd7; bus.c = 16'd7;
            end else if (i == ignore_at + 1) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_after", 64'(bus.busy), 64'd0);
        wait_drain();
        @(negedge clk);
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_done", 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [63:0] n;
        total = 0;
        bad = 0;
        last_prod = '0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_product", 64'(bus.product), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(16'd33, 16'd2, 16'd24, -10);
        run_job(16'd300, 16'd3, 16'd1, -10);
        run_job(16'd300, 16'd3, 16'd1, 4);
        run_job(16'hFFFF, 16'hFFFF, 16'hFFFF, -10);
        run_job(16'd0, 16'd0, 16'd0, -10);

        // Back-to-back with start held: the second job is accepted straight out of DONE.
        @(negedge clk);
        bus.a = 16'd33; bus.b = 16'd2; bus.c = 16'd24; bus.start = 1'b1;
        n = cyc;
        push(16'd33, 16'd2, 16'd24, n + 64'd1 + 64'(W));
        repeat (W + 1) @(negedge clk);
        bus.a = 16'd300; bus.b = 16'd3; bus.c = 16'd1;
        push(16'd300, 16'd3, 16'd1, n + 64'd2 + 64'(2 * W));
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain();
        @(negedge clk);

        // Reset in the middle of a run clears the outputs without waiting for an edge.
        @(negedge clk);
        bus.a = 16'd33; bus.b = 16'd2; bus.c = 16'd24; bus.start = 1'b1;
        push(16'd33, 16'd2, 16'd24, cyc + 64'd1 + 64'(W));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_product", 64'(bus.product), 64'd0);
        last_prod = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        check("post_rst_idle", 64'(bus.busy), 64'd0);
        run_job(16'd33, 16'd2, 16'd24, -10);

        for (int k = 0; k < 20; k++) begin
            run_job(16'($urandom), 16'($urandom), 16'($urandom),
                    (k % 3 == 0) ? int'($urandom_range(0, W - 3)) : -10);
        end

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
